wb_mem_arbiter: RTL

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master (CPU, DMA) Wishbone arbiter for one shared memory slave, with bounded bursts.
// Optional macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of favouring the CPU.
module wb_mem_arbiter #(
  parameter int pDATA_WIDTH = 32,
  parameter int BURST_LEN   = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,

  input  logic                   cpu_cyc_i,
  input  logic                   cpu_stb_i,
  input  logic                   cpu_we_i,
  input  logic [3:0]             cpu_sel_i,
  input  logic [pDATA_WIDTH-1:0] cpu_adr_i,
  input  logic [pDATA_WIDTH-1:0] cpu_dat_i,
  output logic                   cpu_ack_o,
  output logic [pDATA_WIDTH-1:0] cpu_dat_o,

  input  logic                   dma_cyc_i,
  input  logic                   dma_stb_i,
  input  logic                   dma_we_i,
  input  logic [3:0]             dma_sel_i,
  input  logic [pDATA_WIDTH-1:0] dma_adr_i,
  input  logic [pDATA_WIDTH-1:0] dma_dat_i,
  output logic                   dma_ack_o,
  output logic [pDATA_WIDTH-1:0] dma_dat_o,

  output logic                   mem_cyc_o,
  output logic                   mem_stb_o,
  output logic                   mem_we_o,
  output logic [3:0]             mem_sel_o,
  output logic [pDATA_WIDTH-1:0] mem_adr_o,
  output logic [pDATA_WIDTH-1:0] mem_dat_o,
  input  logic                   mem_ack_i,
  input  logic [pDATA_WIDTH-1:0] mem_dat_i,

  output logic [1:0]             grant_o
);

  // state   | meaning
  // IDLE    | no owner, mem_* held at 0, arbitration happens here
  // GNT_CPU | CPU owns the slave, hold_cnt counts its acks
  // GNT_DMA | DMA owns the slave, hold_cnt counts its acks
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_CPU = 2'b01,
    GNT_DMA = 2'b10
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(BURST_LEN - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic       cpu_req;
  logic       dma_req;
  logic       cpu_first;

  assign cpu_req = cpu_cyc_i & cpu_stb_i;
  assign dma_req = dma_cyc_i & dma_stb_i;

`ifdef ARB_ROUND_ROBIN_EN
  // High when the DMA held the most recent grant; resets high so the CPU wins first.
  logic last_gnt;
  assign cpu_first = last_gnt;
`else
  assign cpu_first = 1'b1;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (cpu_req && (!dma_req || cpu_first)) begin
            state <= GNT_CPU;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt <= 1'b0;
`endif
          end else if (dma_req) begin
            state <= GNT_DMA;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt <= 1'b1;
`endif
          end
        end
        GNT_CPU: begin
          if (!cpu_cyc_i) begin
            state <= IDLE;
          end else if (mem_ack_i) begin
            hold_cnt <= hold_cnt + 4'd1;
            if (hold_cnt >= HOLD_MAX) state <= IDLE;
          end
        end
        GNT_DMA: begin
          if (!dma_cyc_i) begin
            state <= IDLE;
          end else if (mem_ack_i) begin
            hold_cnt <= hold_cnt + 4'd1;
            if (hold_cnt >= HOLD_MAX) state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign grant_o = state;

  // Acks are qualified with the owner's cyc so an ack landing on an abort is dropped.
  always_comb begin
    mem_cyc_o = 1'b0;
    mem_stb_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_sel_o = '0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    cpu_ack_o = 1'b0;
    cpu_dat_o = '0;
    dma_ack_o = 1'b0;
    dma_dat_o = '0;
    unique case (state)
      GNT_CPU: begin
        mem_cyc_o = cpu_cyc_i;
        mem_stb_o = cpu_stb_i;
        mem_we_o  = cpu_we_i;
        mem_sel_o = cpu_sel_i;
        mem_adr_o = cpu_adr_i;
        mem_dat_o = cpu_dat_i;
        cpu_ack_o = mem_ack_i & cpu_cyc_i;
        cpu_dat_o = mem_dat_i;
      end
      GNT_DMA: begin
        mem_cyc_o = dma_cyc_i;
        mem_stb_o = dma_stb_i;
        mem_we_o  = dma_we_i;
        mem_sel_o = dma_sel_i;
        mem_adr_o = dma_adr_i;
        mem_dat_o = dma_dat_i;
        dma_ack_o = mem_ack_i & dma_cyc_i;
        dma_dat_o = mem_dat_i;
      end
      default: ;
    endcase
  end

endmodule
